// File: rtl/fwvexrisc_trace_pkg.sv
// +--------------------------------------------------------------------------+
// | fwvexrisc_trace_pkg : record layout, widths and helpers for RVFI tracing  |
// | Layout depends on FWVEXRISC_TRACE_MEM_EN (memory fields appended).        |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

package fwvexrisc_trace_pkg;

    localparam int MAX_NRET   = 4;
    localparam int DROP_CNT_W = 16;
    localparam int ORDER_W    = 64;
    localparam int INSN_W     = 32;
    localparam int RD_W       = 5;

    // Record layout, LSB first: insn, rd_addr, trap, intr, pc, rd_wdata[, mem]
    localparam int OFF_INSN = 0;
    localparam int OFF_RD   = OFF_INSN + INSN_W;
    localparam int OFF_TRAP = OFF_RD + RD_W;
    localparam int OFF_INTR = OFF_TRAP + 1;
    localparam int OFF_PC   = OFF_INTR + 1;

    function automatic int off_wdata(input int xlen);
        return OFF_PC + xlen;
    endfunction

    function automatic int rec_w_core(input int xlen);
        return OFF_PC + 2 * xlen;
    endfunction

    function automatic int off_maddr(input int xlen);
        return rec_w_core(xlen);
    endfunction

    function automatic int off_rmask(input int xlen);
        return off_maddr(xlen) + xlen;
    endfunction

    function automatic int off_wmask(input int xlen);
        return off_rmask(xlen) + xlen / 8;
    endfunction

    function automatic int off_mwdata(input int xlen);
        return off_wmask(xlen) + xlen / 8;
    endfunction

    function automatic int rec_w_mem(input int xlen);
        return off_mwdata(xlen) + xlen;
    endfunction

    function automatic int rec_w(input int xlen);
`ifdef FWVEXRISC_TRACE_MEM_EN
        return rec_w_mem(xlen);
`else
        return rec_w_core(xlen);
`endif
    endfunction

    function automatic logic [2:0] popcount_nret(input logic [MAX_NRET-1:0] v);
        logic [2:0] cnt;
        cnt = '0;
        for (int i = 0; i < MAX_NRET; i++) begin
            cnt = cnt + 3'(v[i]);
        end
        return cnt;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fwvexrisc_trace_fifo.sv
// +--------------------------------------------------------------------------+
// | fwvexrisc_trace_fifo : multi-write (up to NRET), single-read record FIFO  |
// | Write slots must be contiguous from slot 0. Head read from storage flops. |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module fwvexrisc_trace_fifo
    import fwvexrisc_trace_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int NRET  = 1,
    parameter int REC_W = 103
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic [NRET-1:0]         wr_en,
    input  logic [NRET*REC_W-1:0]   wr_data,
    input  logic                    rd_en,
    output logic                    rd_valid,
    output logic [REC_W-1:0]        rd_data,
    output logic [$clog2(DEPTH):0]  level
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW = $clog2(DEPTH) + 1;
    localparam logic [AW-1:0] PTR_MASK = AW'(DEPTH - 1);

    logic [REC_W-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [2:0]       n_wr;
    logic             pop;

    assign n_wr     = popcount_nret(MAX_NRET'(wr_en));
    assign rd_valid = (level != '0);
    assign pop      = rd_en && rd_valid;
    // Gate the head so that an empty FIFO presents all-zero fields.
    assign rd_data  = rd_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clock) begin
        for (int k = 0; k < NRET; k++) begin
            if (wr_en[k]) begin
                mem[(wr_ptr + AW'(k)) & PTR_MASK] <= wr_data[k*REC_W +: REC_W];
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            wr_ptr <= (wr_ptr + AW'(n_wr)) & PTR_MASK;
            rd_ptr <= (rd_ptr + AW'(pop)) & PTR_MASK;
            level  <= level + LW'(n_wr) - LW'(pop);
        end
    end

endmodule

`default_nettype wire

// File: rtl/fwvexrisc_rvfi_trace_buf.sv
// +--------------------------------------------------------------------------+
// | fwvexrisc_rvfi_trace_buf : buffered multi-retire RVFI trace capture with  |
// | order checking, halt latching and drop counting. Memory fields are       |
// | carried only when FWVEXRISC_TRACE_MEM_EN is defined.                     |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module fwvexrisc_rvfi_trace_buf
    import fwvexrisc_trace_pkg::*;
#(
    parameter int NRET  = 1,
    parameter int DEPTH = 16,
    parameter int XLEN  = 32
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic [NRET-1:0]            rvfi_valid,
    input  logic [64*NRET-1:0]         rvfi_order,
    input  logic [32*NRET-1:0]         rvfi_insn,
    input  logic [NRET-1:0]            rvfi_trap,
    input  logic [NRET-1:0]            rvfi_halt,
    input  logic [NRET-1:0]            rvfi_intr,
    input  logic [5*NRET-1:0]          rvfi_rd_addr,
    input  logic [XLEN*NRET-1:0]       rvfi_rd_wdata,
    input  logic [XLEN*NRET-1:0]       rvfi_pc_rdata,
`ifdef FWVEXRISC_TRACE_MEM_EN
    input  logic [XLEN*NRET-1:0]       rvfi_mem_addr,
    input  logic [(XLEN/8)*NRET-1:0]   rvfi_mem_rmask,
    input  logic [(XLEN/8)*NRET-1:0]   rvfi_mem_wmask,
    input  logic [XLEN*NRET-1:0]       rvfi_mem_wdata,
`endif
    output logic                       trc_valid,
    input  logic                       trc_ready,
    output logic [31:0]                trc_insn,
    output logic [XLEN-1:0]            trc_pc,
    output logic [4:0]                 trc_rd_addr,
    output logic [XLEN-1:0]            trc_rd_wdata,
    output logic                       trc_trap,
    output logic                       trc_intr,
`ifdef FWVEXRISC_TRACE_MEM_EN
    output logic [XLEN-1:0]            trc_mem_addr,
    output logic [XLEN/8-1:0]          trc_mem_rmask,
    output logic [XLEN/8-1:0]          trc_mem_wmask,
    output logic [XLEN-1:0]            trc_mem_wdata,
`endif
    output logic [$clog2(DEPTH):0]     level,
    output logic [DROP_CNT_W-1:0]      drop_cnt,
    output logic                       order_err,
    output logic                       halted
);

    localparam int REC_W  = rec_w(XLEN);
    localparam int MW     = XLEN / 8;
    localparam int OFF_WD = off_wdata(XLEN);

    logic [REC_W-1:0]       rec [NRET];
    logic [NRET-1:0]        take;
    logic [NRET-1:0]        slot_en;
    logic [NRET*REC_W-1:0]  slot_data;
    logic [REC_W-1:0]       head;
    logic [ORDER_W-1:0]     exp_order;
    logic [ORDER_W-1:0]     exp_n;
    logic                   first_seen;
    logic                   seen_n;
    logic                   err_n;
    logic                   halt_n;
    logic                   stop;
    logic [2:0]             n_take;
    logic [2:0]             n_write;
    logic [2:0]             n_drop;
    logic [DROP_CNT_W:0]    drop_sum;
    logic [DROP_CNT_W-1:0]  drop_next;
    int                     free_slots;
    int                     rank;

    for (genvar i = 0; i < NRET; i++) begin : g_rec
`ifdef FWVEXRISC_TRACE_MEM_EN
        assign rec[i] = {rvfi_mem_wdata[i*XLEN +: XLEN],
                         rvfi_mem_wmask[i*MW +: MW],
                         rvfi_mem_rmask[i*MW +: MW],
                         rvfi_mem_addr[i*XLEN +: XLEN],
                         rvfi_rd_wdata[i*XLEN +: XLEN],
                         rvfi_pc_rdata[i*XLEN +: XLEN],
                         rvfi_intr[i], rvfi_trap[i],
                         rvfi_rd_addr[i*RD_W +: RD_W],
                         rvfi_insn[i*INSN_W +: INSN_W]};
`else
        assign rec[i] = {rvfi_rd_wdata[i*XLEN +: XLEN],
                         rvfi_pc_rdata[i*XLEN +: XLEN],
                         rvfi_intr[i], rvfi_trap[i],
                         rvfi_rd_addr[i*RD_W +: RD_W],
                         rvfi_insn[i*INSN_W +: INSN_W]};
`endif
    end

    // Channels are walked in index order; a halt stops everything above it.
    always_comb begin
        stop   = halted;
        exp_n  = exp_order;
        seen_n = first_seen;
        err_n  = 1'b0;
        halt_n = 1'b0;
        take   = '0;
        for (int i = 0; i < NRET; i++) begin
            if (!stop && rvfi_valid[i]) begin
                take[i] = 1'b1;
                if (seen_n && (rvfi_order[i*ORDER_W +: ORDER_W] != exp_n)) begin
                    err_n = 1'b1;
                end
                exp_n  = rvfi_order[i*ORDER_W +: ORDER_W] + 64'd1;
                seen_n = 1'b1;
                if (rvfi_halt[i]) begin
                    halt_n = 1'b1;
                    stop   = 1'b1;
                end
            end
        end
    end

    // Free space is taken from the start-of-cycle level; a same-cycle pop does not help.
    always_comb begin
        free_slots = DEPTH - int'(level);
        slot_en    = '0;
        slot_data  = '0;
        rank       = 0;
        for (int k = 0; k < NRET; k++) begin
            rank = 0;
            for (int i = 0; i < NRET; i++) begin
                if (take[i]) begin
                    if ((rank == k) && (k < free_slots)) begin
                        slot_en[k]                     = 1'b1;
                        slot_data[k*REC_W +: REC_W]    = rec[i];
                    end
                    rank = rank + 1;
                end
            end
        end
    end

    assign n_take    = popcount_nret(MAX_NRET'(take));
    assign n_write   = popcount_nret(MAX_NRET'(slot_en));
    assign n_drop    = n_take - n_write;
    assign drop_sum  = {1'b0, drop_cnt} + (DROP_CNT_W+1)'(n_drop);
    assign drop_next = drop_sum[DROP_CNT_W] ? {DROP_CNT_W{1'b1}} : drop_sum[DROP_CNT_W-1:0];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            exp_order  <= '0;
            first_seen <= 1'b0;
            order_err  <= 1'b0;
            halted     <= 1'b0;
            drop_cnt   <= '0;
        end else begin
            exp_order  <= exp_n;
            first_seen <= seen_n;
            order_err  <= order_err | err_n;
            halted     <= halted | halt_n;
            drop_cnt   <= drop_next;
        end
    end

    fwvexrisc_trace_fifo #(
        .DEPTH (DEPTH),
        .NRET  (NRET),
        .REC_W (REC_W)
    ) u_fifo (
        .clock    (clock),
        .reset_n  (reset_n),
        .wr_en    (slot_en),
        .wr_data  (slot_data),
        .rd_en    (trc_ready),
        .rd_valid (trc_valid),
        .rd_data  (head),
        .level    (level)
    );

    assign trc_insn     = head[OFF_INSN +: INSN_W];
    assign trc_rd_addr  = head[OFF_RD +: RD_W];
    assign trc_trap     = head[OFF_TRAP];
    assign trc_intr     = head[OFF_INTR];
    assign trc_pc       = head[OFF_PC +: XLEN];
    assign trc_rd_wdata = head[OFF_WD +: XLEN];
`ifdef FWVEXRISC_TRACE_MEM_EN
    assign trc_mem_addr  = head[off_maddr(XLEN) +: XLEN];
    assign trc_mem_rmask = head[off_rmask(XLEN) +: MW];
    assign trc_mem_wmask = head[off_wmask(XLEN) +: MW];
    assign trc_mem_wdata = head[off_mwdata(XLEN) +: XLEN];
`endif

endmodule

`default_nettype wire

// File: tb/tb_fwvexrisc_rvfi_trace_buf.sv
// +--------------------------------------------------------------------------+
// | tb_fwvexrisc_rvfi_trace_buf : directed self-checking bench, NRET=2,       |
// | DEPTH=8, XLEN=32. Revision: 1.0                                           |
// +--------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module tb_fwvexrisc_rvfi_trace_buf;

    localparam int NRET  = 2;
    localparam int DEPTH = 8;
    localparam int XLEN  = 32;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic                     clock = 1'b0;
    logic                     reset_n;
    logic [NRET-1:0]          rvfi_valid;
    logic [64*NRET-1:0]       rvfi_order;
    logic [32*NRET-1:0]       rvfi_insn;
    logic [NRET-1:0]          rvfi_trap;
    logic [NRET-1:0]          rvfi_halt;
    logic [NRET-1:0]          rvfi_intr;
    logic [5*NRET-1:0]        rvfi_rd_addr;
    logic [XLEN*NRET-1:0]     rvfi_rd_wdata;
    logic [XLEN*NRET-1:0]     rvfi_pc_rdata;
`ifdef FWVEXRISC_TRACE_MEM_EN
    logic [XLEN*NRET-1:0]     rvfi_mem_addr  = '0;
    logic [(XLEN/8)*NRET-1:0] rvfi_mem_rmask = '0;
    logic [(XLEN/8)*NRET-1:0] rvfi_mem_wmask = '0;
    logic [XLEN*NRET-1:0]     rvfi_mem_wdata = '0;
    logic [XLEN-1:0]          trc_mem_addr;
    logic [XLEN/8-1:0]        trc_mem_rmask;
    logic [XLEN/8-1:0]        trc_mem_wmask;
    logic [XLEN-1:0]          trc_mem_wdata;
`endif
    logic                     trc_valid;
    logic                     trc_ready;
    logic [31:0]              trc_insn;
    logic [XLEN-1:0]          trc_pc;
    logic [4:0]               trc_rd_addr;
    logic [XLEN-1:0]          trc_rd_wdata;
    logic                     trc_trap;
    logic                     trc_intr;
    logic [LW-1:0]            level;
    logic [15:0]              drop_cnt;
    logic                     order_err;
    logic                     halted;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    fwvexrisc_rvfi_trace_buf #(
        .NRET  (NRET),
        .DEPTH (DEPTH),
        .XLEN  (XLEN)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .rvfi_valid    (rvfi_valid),
        .rvfi_order    (rvfi_order),
        .rvfi_insn     (rvfi_insn),
        .rvfi_trap     (rvfi_trap),
        .rvfi_halt     (rvfi_halt),
        .rvfi_intr     (rvfi_intr),
        .rvfi_rd_addr  (rvfi_rd_addr),
        .rvfi_rd_wdata (rvfi_rd_wdata),
        .rvfi_pc_rdata (rvfi_pc_rdata),
`ifdef FWVEXRISC_TRACE_MEM_EN
        .rvfi_mem_addr  (rvfi_mem_addr),
        .rvfi_mem_rmask (rvfi_mem_rmask),
        .rvfi_mem_wmask (rvfi_mem_wmask),
        .rvfi_mem_wdata (rvfi_mem_wdata),
`endif
        .trc_valid     (trc_valid),
        .trc_ready     (trc_ready),
        .trc_insn      (trc_insn),
        .trc_pc        (trc_pc),
        .trc_rd_addr   (trc_rd_addr),
        .trc_rd_wdata  (trc_rd_wdata),
        .trc_trap      (trc_trap),
        .trc_intr      (trc_intr),
`ifdef FWVEXRISC_TRACE_MEM_EN
        .trc_mem_addr  (trc_mem_addr),
        .trc_mem_rmask (trc_mem_rmask),
        .trc_mem_wmask (trc_mem_wmask),
        .trc_mem_wdata (trc_mem_wdata),
`endif
        .level         (level),
        .drop_cnt      (drop_cnt),
        .order_err     (order_err),
        .halted        (halted)
    );

    // Record fields are derived from the order number so every head can be predicted.
    function automatic logic [31:0] insn_of(input logic [63:0] o);
        return 32'hA000_0000 + o[31:0];
    endfunction

    function automatic logic [31:0] pc_of(input logic [63:0] o);
        return 32'h8000_0000 + {o[29:0], 2'b00};
    endfunction

    function automatic logic [31:0] wd_of(input logic [63:0] o);
        return o[31:0] ^ 32'h5A5A_5A5A;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int ch, input logic v, input logic [63:0] o, input logic h);
        rvfi_valid[ch]              = v;
        rvfi_order[ch*64 +: 64]     = o;
        rvfi_insn[ch*32 +: 32]      = insn_of(o);
        rvfi_pc_rdata[ch*32 +: 32]  = pc_of(o);
        rvfi_rd_wdata[ch*32 +: 32]  = wd_of(o);
        rvfi_rd_addr[ch*5 +: 5]     = o[4:0];
        rvfi_trap[ch]               = o[1];
        rvfi_intr[ch]               = o[2];
        rvfi_halt[ch]               = h;
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic check_head(input string tag, input logic [63:0] o);
        chk({tag, " valid"}, trc_valid, 1'b1);
        chk({tag, " insn"}, trc_insn, insn_of(o));
        chk({tag, " pc"}, trc_pc, pc_of(o));
        chk({tag, " wdata"}, trc_rd_wdata, wd_of(o));
        chk({tag, " rd"}, trc_rd_addr, o[4:0]);
        chk({tag, " trap"}, trc_trap, o[1]);
        chk({tag, " intr"}, trc_intr, o[2]);
    endtask

    task automatic check_idle(input string tag);
        chk({tag, " valid"}, trc_valid, 1'b0);
        chk({tag, " level"}, level, '0);
        chk({tag, " drop"}, drop_cnt, 16'd0);
        chk({tag, " oerr"}, order_err, 1'b0);
        chk({tag, " halted"}, halted, 1'b0);
        chk({tag, " insn"}, trc_insn, 32'd0);
    endtask

    initial begin
        reset_n   = 1'b0;
        trc_ready = 1'b0;
        rvfi_valid = '0; rvfi_order = '0; rvfi_insn = '0; rvfi_trap = '0;
        rvfi_halt = '0; rvfi_intr = '0; rvfi_rd_addr = '0;
        rvfi_rd_wdata = '0; rvfi_pc_rdata = '0;
        #2;
        check_idle("reset");
        tick; tick;
        reset_n = 1'b1;

        // Single-channel stream with ready held high: one-cycle latency, level stays at 1.
        trc_ready = 1'b1;
        for (int o = 0; o < 5; o++) begin
            drive(0, 1'b1, 64'(o), 1'b0);
            tick;
            check_head($sformatf("t1 head%0d", o), 64'(o));
            chk($sformatf("t1 level%0d", o), level, 1);
        end
        drive(0, 1'b0, 64'd0, 1'b0);
        tick;
        chk("t1 empty valid", trc_valid, 1'b0);
        chk("t1 empty level", level, 0);
        chk("t1 oerr", order_err, 1'b0);

        // Dual-channel burst against a stalled consumer overflows by two records.
        trc_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            drive(0, 1'b1, 64'(5 + 2*c), 1'b0);
            drive(1, 1'b1, 64'(6 + 2*c), 1'b0);
            tick;
            chk($sformatf("t2 fill level%0d", c), level, (c < 4) ? 2*(c+1) : 8);
            chk($sformatf("t2 fill drop%0d", c), drop_cnt, (c == 4) ? 16'd2 : 16'd0);
        end
        drive(0, 1'b0, 64'd0, 1'b0);
        drive(1, 1'b0, 64'd0, 1'b0);
        tick;
        check_head("t2 stall", 64'd5);
        chk("t2 stall level", level, 8);
        trc_ready = 1'b1;
        for (int j = 0; j < 8; j++) begin
            check_head($sformatf("t2 drain%0d", j), 64'(5 + j));
            chk($sformatf("t2 drain level%0d", j), level, 8 - j);
            tick;
        end
        chk("t2 empty valid", trc_valid, 1'b0);
        chk("t2 empty level", level, 0);
        chk("t2 oerr", order_err, 1'b0);

        // Order gap: 15,16 continue from the dropped 13,14; 18 skips 17; 19 resyncs.
        drive(0, 1'b1, 64'd15, 1'b0); tick; chk("t3 oerr15", order_err, 1'b0); check_head("t3 h15", 64'd15);
        drive(0, 1'b1, 64'd16, 1'b0); tick; chk("t3 oerr16", order_err, 1'b0);
        drive(0, 1'b1, 64'd18, 1'b0); tick; chk("t3 oerr18", order_err, 1'b1); check_head("t3 h18", 64'd18);
        drive(0, 1'b1, 64'd19, 1'b0); tick; chk("t3 oerr19", order_err, 1'b1);
        drive(0, 1'b1, 64'd20, 1'b0);
        drive(1, 1'b1, 64'd21, 1'b0);
        tick;
        chk("t3 pair level", level, 2);
        check_head("t3 h20", 64'd20);
        drive(0, 1'b0, 64'd0, 1'b0);
        drive(1, 1'b0, 64'd0, 1'b0);
        tick;
        check_head("t3 h21", 64'd21);
        tick;
        chk("t3 empty level", level, 0);

        // Full FIFO with a simultaneous pop and write: the write is still refused.
        trc_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            drive(0, 1'b1, 64'(22 + 2*c), 1'b0);
            drive(1, 1'b1, 64'(23 + 2*c), 1'b0);
            tick;
        end
        chk("t5 full level", level, 8);
        trc_ready = 1'b1;
        drive(0, 1'b1, 64'd30, 1'b0);
        drive(1, 1'b0, 64'd0, 1'b0);
        tick;
        chk("t5 level", level, 7);
        chk("t5 drop", drop_cnt, 16'd3);
        check_head("t5 h23", 64'd23);
        trc_ready = 1'b0;
        drive(0, 1'b0, 64'd0, 1'b0);
        tick;
        chk("t5 hold level", level, 7);
        check_head("t5 hold", 64'd23);
        chk("t5 oerr", order_err, 1'b1);

        // Asynchronous reset mid-cycle with seven records queued.
        #2;
        reset_n = 1'b0;
        #1;
        check_idle("t6 async");
        tick;
        reset_n = 1'b1;
        tick;
        check_idle("t6 release");

        // Halt on channel 0: channel 1 and every later retire is ignored.
        drive(0, 1'b1, 64'd100, 1'b1);
        drive(1, 1'b1, 64'd200, 1'b0);
        tick;
        chk("t4 halted", halted, 1'b1);
        chk("t4 level", level, 1);
        chk("t4 drop", drop_cnt, 16'd0);
        chk("t4 oerr", order_err, 1'b0);
        check_head("t4 h100", 64'd100);
        drive(0, 1'b1, 64'd300, 1'b0);
        drive(1, 1'b1, 64'd301, 1'b0);
        tick; tick;
        chk("t4 after level", level, 1);
        chk("t4 after drop", drop_cnt, 16'd0);
        chk("t4 after oerr", order_err, 1'b0);
        check_head("t4 after h100", 64'd100);
        trc_ready = 1'b1;
        tick;
        chk("t4 drained valid", trc_valid, 1'b0);
        chk("t4 drained level", level, 0);
        chk("t4 still halted", halted, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
